// File: rtl/pin_pkg.sv
// Shared definitions for the parking-gate keypad path: key codes, PIN width,
// FSM state encoding and a key classifier.
package pin_pkg;

  localparam int PIN_DIGITS = 2;
  localparam int PIN_W      = 4 * PIN_DIGITS;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam logic [2:0] ST_EMPTY = 3'b001;
  localparam logic [2:0] ST_ONE   = 3'b010;
  localparam logic [2:0] ST_TWO   = 3'b100;

  typedef enum logic [1:0] {
    KEY_DIGIT,
    KEY_CLR,
    KEY_ENT,
    KEY_RSVD
  } key_kind_e;

  function automatic key_kind_e classify_key(input logic [3:0] code);
    if (code <= 4'd9)           return KEY_DIGIT;
    else if (code == KEY_CLEAR) return KEY_CLR;
    else if (code == KEY_ENTER) return KEY_ENT;
    else                        return KEY_RSVD;
  endfunction

endpackage

// File: rtl/pin_keypad_if.sv
// Keypad scanner / gate controller side bundle: key level and code in,
// assembled PIN plus status pulses out.
interface pin_keypad_if;
  import pin_pkg::*;

  logic             Key_valid;
  logic [3:0]       Key_code;
  logic [PIN_W-1:0] Pin;
  logic             enterPin;
  logic             Pin_error;
  logic             Timeout;
  logic [1:0]       Digits;

  modport master (
    output Key_valid, Key_code,
    input  Pin, enterPin, Pin_error, Timeout, Digits
  );

  modport slave (
    input  Key_valid, Key_code,
    output Pin, enterPin, Pin_error, Timeout, Digits
  );

endinterface

// File: rtl/pin_keypad_key_edge_detect.sv
// Rising-edge detector on the scanner's key level; the history register
// resets high so a key held through reset is not taken as a new press.
module key_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic Key_valid,
  output logic key_press
);

  logic prev_valid_reg;

  always_ff @(posedge Clk) begin
    if (Reset) prev_valid_reg <= 1'b1;
    else       prev_valid_reg <= Key_valid;
  end

  assign key_press = Key_valid & ~prev_valid_reg;

endmodule

// File: rtl/pin_keypad.sv
// Keypad front end: collects two BCD digits into the PIN word, strobes
// enterPin on a complete entry, and clears on CLEAR, bad ENTER or inactivity.
module pin_keypad
  import pin_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic         Clk,
  input  logic         Reset,
  pin_keypad_if.slave  kp
);

  logic             key_press;
  key_kind_e        key_kind;
  logic             expired;

  logic [2:0]       state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [1:0]       digits_reg, digits_next;
  logic             enter_reg, enter_next;
  logic             error_reg, error_next;
  logic             timeout_reg, timeout_next;
  logic             shift_en, zero_en;
  logic [3:0]       digit_reg [PIN_DIGITS];

  key_edge_detect u_edge (
    .Clk       (Clk),
    .Reset     (Reset),
    .Key_valid (kp.Key_valid),
    .key_press (key_press)
  );

  assign key_kind = classify_key(kp.Key_code);
  assign expired  = (state_reg != ST_EMPTY) &&
                    (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

  // Accepted presses take priority over the expiry of the inactivity timer.
  always_comb begin
    state_next   = state_reg;
    timer_next   = '0;
    enter_next   = 1'b0;
    error_next   = 1'b0;
    timeout_next = 1'b0;
    shift_en     = 1'b0;
    zero_en      = 1'b0;
    if (key_press && key_kind == KEY_DIGIT) begin
      shift_en   = 1'b1;
      state_next = (state_reg == ST_EMPTY) ? ST_ONE : ST_TWO;
    end else if (key_press && key_kind == KEY_CLR) begin
      zero_en    = 1'b1;
      state_next = ST_EMPTY;
    end else if (key_press && key_kind == KEY_ENT) begin
      if (state_reg == ST_TWO) begin
        enter_next = 1'b1;
      end else begin
        error_next = 1'b1;
        zero_en    = 1'b1;
      end
      state_next = ST_EMPTY;
    end else if (expired) begin
      timeout_next = 1'b1;
      zero_en      = 1'b1;
      state_next   = ST_EMPTY;
    end else if (state_reg != ST_EMPTY) begin
      timer_next = timer_reg + TMR_W'(1);
    end
  end

  always_comb begin
    case (state_next)
      ST_ONE:  digits_next = 2'd1;
      ST_TWO:  digits_next = 2'd2;
      default: digits_next = 2'd0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= ST_EMPTY;
      timer_reg   <= '0;
      digits_reg  <= 2'd0;
      enter_reg   <= 1'b0;
      error_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      digits_reg  <= digits_next;
      enter_reg   <= enter_next;
      error_reg   <= error_next;
      timeout_reg <= timeout_next;
    end
  end

  // Lane 0 holds the newest digit in Pin[3:0]; each shift ages lanes upward.
  genvar gi;
  generate
    for (gi = 0; gi < PIN_DIGITS; gi++) begin : g_lane
      always_ff @(posedge Clk) begin
        if (Reset || zero_en) begin
          digit_reg[gi] <= 4'h0;
        end else if (shift_en) begin
          if (gi == 0) digit_reg[gi] <= kp.Key_code;
          else         digit_reg[gi] <= digit_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
      assign kp.Pin[4*gi +: 4] = digit_reg[gi];
    end
  endgenerate

  assign kp.Digits    = digits_reg;
  assign kp.enterPin  = enter_reg;
  assign kp.Pin_error = error_reg;
  assign kp.Timeout   = timeout_reg;

endmodule

// File: tb/tb_pin_keypad.sv
// Directed bench for pin_keypad with a queue-based reference model checked
// every cycle, plus literal expectations for the listed scenarios.
module tb_pin_keypad;
  import pin_pkg::*;

  localparam int T = 32;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  pin_keypad_if kp ();

  pin_keypad #(.TIMEOUT_CYCLES(T)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .kp    (kp)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  bit checking = 0;

  // Reference model: digits held in a queue, expiry measured as elapsed
  // cycles since the last accepted digit.
  int         q[$];
  logic [7:0] m_pin = 8'h00;
  bit         m_enter = 0, m_err = 0, m_tmo = 0;
  bit         m_prev = 1, m_press = 0;
  int         cyc = 0, last_digit = 0;

  always @(posedge Clk) begin
    cyc++;
    m_enter = 0;
    m_err   = 0;
    m_tmo   = 0;
    if (Reset) begin
      q.delete();
      m_pin  = 8'h00;
      m_prev = 1;
    end else begin
      m_press = kp.Key_valid && !m_prev;
      m_prev  = kp.Key_valid;
      if (m_press && kp.Key_code <= 4'd9) begin
        q.push_back(int'(kp.Key_code));
        if (q.size() > 2) void'(q.pop_front());
        m_pin = {m_pin[3:0], kp.Key_code};
        last_digit = cyc;
      end else if (m_press && kp.Key_code == 4'hA) begin
        q.delete();
        m_pin = 8'h00;
      end else if (m_press && kp.Key_code == 4'hB) begin
        if (q.size() == 2) m_enter = 1;
        else begin
          m_err = 1;
          m_pin = 8'h00;
        end
        q.delete();
      end else if (q.size() > 0 && cyc - last_digit == T) begin
        m_tmo = 1;
        q.delete();
        m_pin = 8'h00;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (checking) begin
      chk("model_pin",     32'(kp.Pin),       32'(m_pin));
      chk("model_digits",  32'(kp.Digits),    q.size());
      chk("model_enter",   32'(kp.enterPin),  32'(m_enter));
      chk("model_error",   32'(kp.Pin_error), 32'(m_err));
      chk("model_timeout", 32'(kp.Timeout),   32'(m_tmo));
    end
  end

  task automatic press(input logic [3:0] c);
    @(negedge Clk);
    kp.Key_valid = 1'b1;
    kp.Key_code  = c;
    @(negedge Clk);
    kp.Key_valid = 1'b0;
  endtask

  task automatic wait_timeout(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= T + 8; i++) begin
      @(negedge Clk);
      if (kp.Timeout === 1'b1) begin
        k = i;
        break;
      end
    end
    chk(name, k, T);
  endtask

  initial begin
    kp.Key_valid = 1'b0;
    kp.Key_code  = 4'h0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    checking = 1;
    chk("reset_pin", 32'(kp.Pin), 0);
    chk("reset_digits", 32'(kp.Digits), 0);
    chk("reset_pulses", {kp.enterPin, kp.Pin_error, kp.Timeout}, 0);

    // 1, 0, ENTER
    press(4'h1);
    chk("s1_digits_1", 32'(kp.Digits), 1);
    press(4'h0);
    chk("s1_digits_2", 32'(kp.Digits), 2);
    chk("s1_pin", 32'(kp.Pin), 32'h10);
    press(4'hB);
    chk("s1_enter", 32'(kp.enterPin), 1);
    chk("s1_enter_pin", 32'(kp.Pin), 32'h10);
    chk("s1_digits_0", 32'(kp.Digits), 0);
    @(negedge Clk);
    chk("s1_enter_width", 32'(kp.enterPin), 0);
    chk("s1_pin_hold", 32'(kp.Pin), 32'h10);

    // 3, 4, 5, ENTER then 7, ENTER
    press(4'h3);
    press(4'h4);
    press(4'h5);
    chk("s2_shift_digits", 32'(kp.Digits), 2);
    press(4'hB);
    chk("s2_enter", 32'(kp.enterPin), 1);
    chk("s2_pin", 32'(kp.Pin), 32'h45);
    press(4'h7);
    press(4'hB);
    chk("s2_error", 32'(kp.Pin_error), 1);
    chk("s2_no_enter", 32'(kp.enterPin), 0);
    chk("s2_err_pin", 32'(kp.Pin), 0);

    // 9 then idle until expiry
    press(4'h9);
    wait_timeout("s3_timeout_latency");
    chk("s3_pin", 32'(kp.Pin), 0);
    chk("s3_digits", 32'(kp.Digits), 0);

    // Long hold accepts a single digit; reserved code is ignored
    @(negedge Clk);
    kp.Key_valid = 1'b1;
    kp.Key_code  = 4'h2;
    repeat (20) @(negedge Clk);
    chk("s4_hold_digits", 32'(kp.Digits), 1);
    chk("s4_hold_pin", 32'(kp.Pin), 32'h02);
    kp.Key_valid = 1'b0;
    press(4'hE);
    chk("s4_rsvd_digits", 32'(kp.Digits), 1);
    chk("s4_rsvd_pin", 32'(kp.Pin), 32'h02);
    press(4'hA);
    chk("s4_clear_digits", 32'(kp.Digits), 0);
    chk("s4_clear_pin", 32'(kp.Pin), 0);

    // Reset while key 0 is held
    press(4'h1);
    @(negedge Clk);
    kp.Key_valid = 1'b1;
    kp.Key_code  = 4'h0;
    @(negedge Clk);
    chk("s5_pre_digits", 32'(kp.Digits), 2);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("s5_reset_pin", 32'(kp.Pin), 0);
    chk("s5_reset_digits", 32'(kp.Digits), 0);
    chk("s5_reset_pulses", {kp.enterPin, kp.Pin_error, kp.Timeout}, 0);
    repeat (3) @(negedge Clk);
    chk("s5_held_ignored", 32'(kp.Digits), 0);
    kp.Key_valid = 1'b0;
    press(4'h0);
    chk("s5_repress", 32'(kp.Digits), 1);
    press(4'hA);

    // Digit lands in the expiry cycle
    press(4'h5);
    repeat (T - 2) @(negedge Clk);
    press(4'h7);
    chk("s6_no_timeout", 32'(kp.Timeout), 0);
    chk("s6_digits", 32'(kp.Digits), 2);
    chk("s6_pin", 32'(kp.Pin), 32'h57);
    wait_timeout("s6_restart_latency");
    chk("s6_final_pin", 32'(kp.Pin), 0);
    chk("s6_final_digits", 32'(kp.Digits), 0);

    repeat (3) @(negedge Clk);
    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pin_keypad.md
# pin_keypad

Keypad front end for the parking-gate controller. Collects BCD digit keypresses into the 8-bit PIN word and issues the one-cycle `enterPin` strobe that the gate controller samples, so the controller always sees a stable, complete two-digit PIN. It also clears partial entries on user request or after an inactivity timeout, and flags premature enter presses.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed mid-entry before the buffer is discarded. Legal range is 2 or more.
- `TMR_W`, default `$clog2(TIMEOUT_CYCLES)`: width of the inactivity timer.

Ports:
- `Clk`  in  1  single clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Key_valid`  in  1  level from the keypad scanner; high while a key is held.
- `Key_code`  in  4  code of the held key: 0x0–0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC–0xF reserved.
- `Pin`  out  8  assembled PIN; first digit in [7:4], second digit in [3:0] (BCD).
- `enterPin`  out  1  one-cycle strobe; `Pin` is valid in the same cycle.
- `Pin_error`  out  1  one-cycle pulse when ENTER is pressed with fewer than 2 digits.
- `Timeout`  out  1  one-cycle pulse when a partial or complete entry expires.
- `Digits`  out  2  number of digits currently buffered (0, 1 or 2).

## Operation
- Press detect: a press is accepted in a cycle where `Key_valid`=1 and the registered previous `Key_valid`=0. One press is accepted per assertion, however long the key is held.
- States:
  - EMPTY (`Digits`=0)
  - ONE (`Digits`=1)
  - TWO (`Digits`=2)
- Digit press: `Pin` <= {`Pin[3:0]`, code}.
  - EMPTY → ONE, ONE → TWO.
  - In TWO, a digit shifts out the oldest digit and the state stays TWO.
- CLEAR press: `Pin` <= 0, go to EMPTY. No pulse is issued.
- ENTER press in TWO: `enterPin`=1 next cycle with `Pin` unchanged, then go to EMPTY. `Pin` holds its value until the next digit or CLEAR.
- ENTER press in EMPTY or ONE: `Pin_error`=1 next cycle, `Pin` <= 0, go to EMPTY. No `enterPin`.
- Reserved codes 0xC–0xF: ignored, and they do not restart the timer.
- Inactivity timer:
  - Runs only in ONE and TWO; restarts to 0 on every accepted digit.
  - Held at 0 in EMPTY.
  - On reaching `TIMEOUT_CYCLES`-1: `Timeout`=1 next cycle, `Pin` <= 0, go to EMPTY.

## Timing
- Reset values:
  - `Pin`=0, `enterPin`=0, `Pin_error`=0, `Timeout`=0, `Digits`=0.
  - Timer=0, state EMPTY.
  - Previous-`Key_valid` register = 1, so a key held through reset is ignored until it is released.
- Latency: a press accepted in cycle N is reflected in `Pin`, `Digits` and the pulses in cycle N+1.
- All outputs are registered. `enterPin`, `Pin_error` and `Timeout` are each exactly 1 cycle wide and are mutually exclusive.
- Simultaneous events:
  - An accepted press in the expiry cycle wins; `Timeout` is suppressed.
  - A digit press restarts the timer.
  - An ENTER or CLEAR press empties the buffer.
- `Reset` asserted mid-entry discards the buffer. No pulse is emitted during or after reset.
- Back-to-back presses are limited by `Key_valid` needing one low cycle between presses: minimum 2 cycles per key.

## Structure
- Shared package `pin_pkg`:
  - key-code constants `KEY_CLEAR`=4'hA, `KEY_ENTER`=4'hB
  - `PIN_DIGITS`=2
  - state encoding (one-hot, 3 bits)
- The gate controller imports the same package for PIN width.
- Sub-module `key_edge_detect`: the previous-`Key_valid` register (reset value 1) and the rising-edge output.
- The FSM, shift register and timer stay in `pin_keypad`.

## Test plan
- Press 1, release, press 0, release, press ENTER → `Pin`=8'h10 with `enterPin`=1 for 1 cycle; `Digits` goes 1, 2, 0.
- Press 3, 4, 5, then ENTER → `Pin`=8'h45 and `enterPin` pulse. Press 7 then ENTER → `Pin_error` pulse, `Pin`=0, no `enterPin`.
- Press 9, then idle `TIMEOUT_CYCLES` cycles → `Timeout` pulse exactly `TIMEOUT_CYCLES` cycles after the press, `Pin`=0, `Digits`=0.
- Hold `Key_valid`=1 with code 2 for 20 cycles → exactly one digit accepted (`Digits`=1, `Pin`=8'h02). Reserved code 0xE → no change.
- Enter digits 1, 0, assert `Reset` for 1 cycle while key 0 is still held → all outputs 0. The held key is not re-accepted until it is released and pressed again.
- Digit press landing in the timer-expiry cycle → no `Timeout`, digit shifted in, timer restarted.
